// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding, NOP word
// and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority, highest first: reset, stall (hold),
// flush, load of a delivered instruction, otherwise a bubble.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_d,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (stall_d) begin
      instr_d    = instr_q;
    end else if (flush) begin
      instr_d    = NOP_WORD;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end else begin
      // Bubble: PC+4 is meaningless without a valid instruction, so clear it.
      instr_d    = NOP_WORD;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, request/hold/drop FSM and IF/ID register.
// Define FETCH_PERF_CNT_EN to build the FetchCnt/ImemWaitCnt performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  input  logic        ImemValid,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] FetchCnt,
  output logic [31:0] ImemWaitCnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc4_q, hold_pc4_d;

  logic        redirect;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc4;
  logic [31:0] pcf_plus4;

  // A redirect arriving while Decode is stalled belongs to a stale instruction.
  assign redirect  = PCSrcD & ~StallD;
  assign pcf_plus4 = pcf_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pcf_d         = pcf_q;
    drop_addr_d   = drop_addr_q;
    hold_instr_d  = hold_instr_q;
    hold_pc4_d    = hold_pc4_q;
    deliver       = 1'b0;
    deliver_instr = NOP_WORD;
    deliver_pc4   = '0;
    case (state_q)
      ST_REQ: begin
        if (redirect) begin
          pcf_d = PCBranchD;
          if (!ImemValid) begin
            drop_addr_d = pcf_q;
            state_d     = ST_DROP;
          end
        end else if (ImemValid) begin
          pcf_d = pcf_plus4;
          if (StallF) begin
            hold_instr_d = ImemRdata;
            hold_pc4_d   = pcf_plus4;
            state_d      = ST_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = ImemRdata;
            deliver_pc4   = pcf_plus4;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pcf_d   = PCBranchD;
          state_d = ST_REQ;
        end else if (!StallF) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          deliver_pc4   = hold_pc4_q;
          state_d       = ST_REQ;
        end
      end
      ST_DROP: begin
        // The in-flight response belongs to the old path; the request address
        // stays on it until the memory answers.
        if (redirect) begin
          pcf_d = PCBranchD;
        end
        if (ImemValid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pcf_q        <= RESET_PC;
      drop_addr_q  <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      drop_addr_q  <= drop_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  assign ImemReq  = (state_q != ST_HOLD);
  assign ImemAddr = (state_q == ST_DROP) ? drop_addr_q : pcf_q;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .stall_d    (StallD),
    .flush      (redirect),
    .load       (deliver),
    .instr_in   (deliver_instr),
    .pc_plus4_in(deliver_pc4),
    .instr_o    (InstrD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  // A delivery only lands in IF/ID when Decode is not stalled.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (deliver && !StallD) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (ImemReq && !ImemValid) begin
      wait_cnt_d = wait_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign FetchCnt    = fetch_cnt_q;
  assign ImemWaitCnt = wait_cnt_q;
`else
  assign FetchCnt    = '0;
  assign ImemWaitCnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a behavioural model of
// the fetch rules and a variable-latency instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, PCSrcD;
  logic [31:0] PCBranchD;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        ImemValid;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD;
  logic [31:0] FetchCnt, ImemWaitCnt;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemRdata  (ImemRdata),
    .ImemValid  (ImemValid),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchCnt   (FetchCnt),
    .ImemWaitCnt(ImemWaitCnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: next PC, an optional buffered word, and an optional
  // outstanding response that must be thrown away.
  logic [31:0] m_pc;
  word_t       m_buf[$];
  bit          m_stale;
  logic [31:0] m_stale_addr;
  bit          e_valid;
  logic [31:0] e_instr;
  logic [31:0] e_pc4;
  bit          e_pc4_care;
  logic [31:0] e_fetch;
  logic [31:0] e_wait;

  int unsigned mem_age = 0;
  int unsigned mem_lat = 0;
  int unsigned lat_max = 0;

  function automatic logic [31:0] dataOf(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the model, and checks after the edge.
  task automatic applyStimulus(input bit r, input bit sf, input bit sd, input bit ps,
                               input logic [31:0] tgt);
    bit          req, vld, redir, dlv;
    logic [31:0] addr;
    word_t       w;
    req  = (m_buf.size() == 0);
    addr = m_stale ? m_stale_addr : m_pc;
    vld  = !r && req && (mem_age >= mem_lat);
    rst       = r;
    StallF    = sf;
    StallD    = sd;
    PCSrcD    = ps;
    PCBranchD = tgt;
    ImemValid = vld;
    ImemRdata = vld ? dataOf(addr) : $urandom();

    dlv = 1'b0;
    w   = '0;
    if (r) begin
      m_pc       = TB_RESET_PC;
      m_buf.delete();
      m_stale    = 1'b0;
      e_valid    = 1'b0;
      e_instr    = '0;
      e_pc4      = '0;
      e_pc4_care = 1'b1;
      e_fetch    = '0;
      e_wait     = '0;
    end else begin
      redir = ps && !sd;
      if (m_buf.size() != 0) begin
        if (redir) begin
          m_buf.delete();
          m_pc = tgt;
        end else if (!sf) begin
          w   = m_buf.pop_front();
          dlv = 1'b1;
        end
      end else if (m_stale) begin
        if (vld) m_stale = 1'b0;
        if (redir) m_pc = tgt;
      end else if (redir) begin
        if (!vld) begin
          m_stale      = 1'b1;
          m_stale_addr = m_pc;
        end
        m_pc = tgt;
      end else if (vld) begin
        w.instr = dataOf(m_pc);
        w.pc4   = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        if (sf) m_buf.push_back(w);
        else dlv = 1'b1;
      end
      if (req && !vld) e_wait = e_wait + 32'd1;
      if (sd) begin
        e_valid = e_valid;
      end else if (redir) begin
        e_valid    = 1'b0;
        e_instr    = '0;
        e_pc4      = '0;
        e_pc4_care = 1'b1;
      end else if (dlv) begin
        e_valid    = 1'b1;
        e_instr    = w.instr;
        e_pc4      = w.pc4;
        e_pc4_care = 1'b1;
        e_fetch    = e_fetch + 32'd1;
      end else begin
        e_valid    = 1'b0;
        e_instr    = '0;
        e_pc4_care = 1'b0;
      end
    end

    if (r || vld) begin
      mem_age = 0;
      mem_lat = $urandom_range(lat_max, 0);
    end else if (req) begin
      mem_age++;
    end

    @(posedge clk);
    #1;
    checkOutput("ImemReq", {31'd0, ImemReq}, {31'd0, m_buf.size() == 0});
    if (m_buf.size() == 0)
      checkOutput("ImemAddr", ImemAddr, m_stale ? m_stale_addr : m_pc);
    checkOutput("ValidD", {31'd0, ValidD}, {31'd0, e_valid});
    checkOutput("InstrD", InstrD, e_instr);
    if (e_pc4_care) checkOutput("PCPlus4D", PCPlus4D, e_pc4);
    checkOutput("FetchCnt", FetchCnt, PERF_EN ? e_fetch : 32'd0);
    checkOutput("ImemWaitCnt", ImemWaitCnt, PERF_EN ? e_wait : 32'd0);
  endtask

  initial begin
    bit          r, sf, sd, ps;
    logic [31:0] tgt;

    // Zero-wait memory, no stalls: sequential fetch from the reset PC.
    lat_max = 0;
    applyStimulus(1, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("reset_addr", ImemAddr, TB_RESET_PC);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, '0);
    checkOutput("seq_pc4_last", PCPlus4D, 32'h10);
    checkOutput("seq_next_addr", ImemAddr, 32'h10);

    // Stall while the word for 0x8 arrives, hold for 3 cycles, then release.
    applyStimulus(1, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, '0);
    checkOutput("hold_req_low", {31'd0, ImemReq}, 32'd0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("hold_release_pc4", PCPlus4D, 32'hC);
    checkOutput("hold_release_valid", {31'd0, ValidD}, 32'd1);

    // Redirect during a 3-cycle wait, then a redirect ignored under StallD.
    lat_max = 3;
    applyStimulus(1, 0, 0, 0, '0);
    mem_lat = 3;
    applyStimulus(0, 0, 0, 1, 32'h100);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 1, 1, 1, 32'h200);
    applyStimulus(0, 0, 0, 0, '0);

    // PC wrap at the top of the address space.
    lat_max = 1;
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, '0);

    // Reset in the middle of a wait.
    lat_max = 3;
    mem_lat = 3;
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("midwait_reset_valid", {31'd0, ValidD}, 32'd0);
    applyStimulus(0, 0, 0, 0, '0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      lat_max = (i % 1000 < 300) ? 0 : 3;
      r   = ($urandom_range(199, 0) == 0);
      sf  = ($urandom_range(9, 0) < 3);
      sd  = ($urandom_range(9, 0) < 2) ? 1'b1 : sf & ($urandom_range(1, 0) == 1);
      ps  = ($urandom_range(9, 0) == 0);
      tgt = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF0 + {$urandom_range(3, 0), 2'b00}
                                        : ($urandom() & 32'hFFFF_FFFC);
      applyStimulus(r, sf, sd, ps, tgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
